// File: rtl/exec_pkg.sv
// ----------------------------------------------------------------------------
// exec_pkg
// Shared encodings for the execute stage of the 8-bit pipelined core:
//   - aluop operation classes driven by the control unit through ID/EX
//   - 4-bit ALU operation codes consumed by the ALU select
//   - funct7 values that distinguish ADD/SUB and SRL/SRA
// ----------------------------------------------------------------------------
package exec_pkg;

    localparam int DATA_W = 8;

    // Operation class from the control unit
    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    // ALU operation codes
    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_XOR     = 4'b0011;
    localparam logic [3:0] ALU_SLL     = 4'b0100;
    localparam logic [3:0] ALU_SRL     = 4'b0101;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_SRA     = 4'b0111;
    localparam logic [3:0] ALU_SLT     = 4'b1000;
    localparam logic [3:0] ALU_SLTU    = 4'b1001;
    localparam logic [3:0] ALU_NOR     = 4'b1100;
    localparam logic [3:0] ALU_INVALID = 4'b1111;

    // funct7 qualifiers
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/exec_pc_core_alu_ctrl_decode.sv
// ----------------------------------------------------------------------------
// alu_ctrl_decode
// Purely combinational ALU-control decoder.
// Ports:
//   aluop  [1:0] in  - operation class (mem / branch / R-type / I-type)
//   funct3 [2:0] in  - instruction funct3
//   funct7 [6:0] in  - instruction funct7
//   aluopc [3:0] out - ALU operation code, ALU_INVALID for bad funct7
// ----------------------------------------------------------------------------
module alu_ctrl_decode
    import exec_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] aluopc
);

    logic is_itype;

    always_comb begin
        aluopc   = ALU_INVALID;
        is_itype = (aluop == ALUOP_I);
        case (aluop)
            ALUOP_MEM: aluopc = ALU_ADD;
            ALUOP_BR:  aluopc = ALU_SUB;
            default: begin
                // R-type and I-type share the funct3 map; only 000 (where an
                // immediate has no funct7) and 101 differ in funct7 handling.
                case (funct3)
                    3'b000: begin
                        if (is_itype || funct7 == F7_BASE) aluopc = ALU_ADD;
                        else if (funct7 == F7_ALT)         aluopc = ALU_SUB;
                        else                               aluopc = ALU_INVALID;
                    end
                    3'b111: aluopc = ALU_AND;
                    3'b110: aluopc = ALU_OR;
                    3'b100: aluopc = ALU_XOR;
                    3'b001: aluopc = ALU_SLL;
                    3'b101: begin
                        if (funct7 == F7_BASE)     aluopc = ALU_SRL;
                        else if (funct7 == F7_ALT) aluopc = ALU_SRA;
                        else                       aluopc = ALU_INVALID;
                    end
                    3'b010: aluopc = ALU_SLT;
                    3'b011: aluopc = ALU_SLTU;
                    default: aluopc = ALU_INVALID;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/exec_pc_core.sv
// ----------------------------------------------------------------------------
// exec_pc_core
// Execute-stage core: program counter, ALU-control decode and 8-bit ALU.
// Parameters:
//   PC_STEP  - PC increment per cycle (wraps mod 256)
//   PC_RESET - PC value loaded while reset is high
// Ports:
//   clk          in  - rising-edge clock
//   reset        in  - synchronous active-high reset (PC only)
//   pcout  [7:0] out - registered program counter
//   aluop  [1:0] in  - operation class via ID/EX
//   funct3 [2:0] in  - funct3 via ID/EX
//   funct7 [6:0] in  - funct7 via ID/EX
//   a      [7:0] in  - operand A
//   b      [7:0] in  - operand B (register or immediate)
//   aluopc [3:0] out - decoded ALU operation code (combinational)
//   result [7:0] out - ALU result (combinational)
//   zero         out - result == 0
// ----------------------------------------------------------------------------
module exec_pc_core
    import exec_pkg::*;
#(
    parameter int         PC_STEP  = 4,
    parameter logic [7:0] PC_RESET = 8'h00
)(
    input  logic              clk,
    input  logic              reset,
    output logic [DATA_W-1:0] pcout,
    input  logic [1:0]        aluop,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [3:0]        aluopc,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    localparam logic [DATA_W-1:0] STEP = PC_STEP[DATA_W-1:0];

    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q + STEP;
    end

    always_ff @(posedge clk) begin
        if (reset) pc_q <= PC_RESET;
        else       pc_q <= pc_d;
    end

    assign pcout = pc_q;

    alu_ctrl_decode u_decode (
        .aluop  (aluop),
        .funct3 (funct3),
        .funct7 (funct7),
        .aluopc (aluopc)
    );

    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic        [2:0]        shamt;

    always_comb begin
        a_s    = signed'(a);
        b_s    = signed'(b);
        shamt  = b[2:0];
        result = '0;
        case (aluopc)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_ADD:  result = a + b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SUB:  result = a - b;
            ALU_SRA:  result = unsigned'(a_s >>> shamt);
            ALU_SLT:  result = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
            ALU_NOR:  result = ~(a | b);
            default:  result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: tb/tb_exec_pc_core.sv
module tb_exec_pc_core;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pcout;
    logic [1:0] aluop;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [7:0] a, b;
    logic [3:0] aluopc;
    logic [7:0] result;
    logic       zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    exec_pc_core #(.PC_STEP(4), .PC_RESET(8'h00)) dut (
        .clk    (clk),
        .reset  (reset),
        .pcout  (pcout),
        .aluop  (aluop),
        .funct3 (funct3),
        .funct7 (funct7),
        .a      (a),
        .b      (b),
        .aluopc (aluopc),
        .result (result),
        .zero   (zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [7:0] va;
        logic [7:0] vb;
        logic [3:0] e_opc;
        logic [7:0] e_res;
        logic       e_zero;
    } vec_t;

    // Reference: decode by the instruction-level meaning, returns op code.
    function automatic logic [3:0] ref_opc(input logic [1:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7);
        bit alt  = (f7 == 7'h20);
        bit base = (f7 == 7'h00);
        if (op == 2'd0) return 4'd2;
        if (op == 2'd1) return 4'd6;
        if (f3 == 3'd0) begin
            if (op == 2'd3 || base) return 4'd2;
            return alt ? 4'd6 : 4'd15;
        end
        if (f3 == 3'd5) return base ? 4'd5 : (alt ? 4'd7 : 4'd15);
        if (f3 == 3'd7) return 4'd0;
        if (f3 == 3'd6) return 4'd1;
        if (f3 == 3'd4) return 4'd3;
        if (f3 == 3'd1) return 4'd4;
        if (f3 == 3'd2) return 4'd8;
        return 4'd9;
    endfunction

    // Reference ALU in plain integer arithmetic.
    function automatic logic [7:0] ref_res(input logic [3:0] opc, input int ua, input int ub);
        int sa = (ua >= 128) ? ua - 256 : ua;
        int sb = (ub >= 128) ? ub - 256 : ub;
        int sh = ub % 8;
        int r;
        case (opc)
            4'd0:  r = ua & ub;
            4'd1:  r = ua | ub;
            4'd2:  r = (ua + ub) % 256;
            4'd3:  r = ua ^ ub;
            4'd4:  r = (ua * (1 << sh)) % 256;
            4'd5:  r = ua / (1 << sh);
            4'd6:  r = (ua - ub + 256) % 256;
            4'd7:  r = (sa >>> sh) & 255;
            4'd8:  r = (sa < sb) ? 1 : 0;
            4'd9:  r = (ua < ub) ? 1 : 0;
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    vec_t vecs[$];

    initial begin
        int exp_pc;
        logic [3:0] eo;
        logic [7:0] er;

        aluop = 0; funct3 = 0; funct7 = 0; a = 0; b = 0;

        // PC reset and increment
        reset = 1'b1;
        @(posedge clk); #1;
        check("pc_reset", pcout, 8'h00);
        reset = 1'b0;
        for (int i = 1; i <= 74; i++) begin
            @(posedge clk); #1;
            exp_pc = (i * 4) % 256;
            check($sformatf("pc_inc%0d", i), pcout, exp_pc[7:0]);
        end
        // pcout is now 40: mid-run reset
        reset = 1'b1;
        @(posedge clk); #1;
        check("pc_midreset", pcout, 8'h00);
        reset = 1'b0;
        @(posedge clk); #1;
        check("pc_after_midreset", pcout, 8'h04);
        @(posedge clk); #1;
        check("pc_after_midreset2", pcout, 8'h08);

        // Directed vectors
        vecs.push_back('{"r_add",   2'b10, 3'b000, 7'h00, 8'd100, 8'd200, 4'b0010, 8'd44, 1'b0});
        vecs.push_back('{"r_sub",   2'b10, 3'b000, 7'h20, 8'd5,   8'd5,   4'b0110, 8'd0,  1'b1});
        vecs.push_back('{"mem_add", 2'b00, 3'b111, 7'h7F, 8'h10,  8'h04,  4'b0010, 8'h14, 1'b0});
        vecs.push_back('{"br_sub",  2'b01, 3'b101, 7'h20, 8'h03,  8'h05,  4'b0110, 8'hFE, 1'b0});
        vecs.push_back('{"and",     2'b10, 3'b111, 7'h00, 8'hF0,  8'h3C,  4'b0000, 8'h30, 1'b0});
        vecs.push_back('{"or",      2'b10, 3'b110, 7'h00, 8'hF0,  8'h3C,  4'b0001, 8'hFC, 1'b0});
        vecs.push_back('{"xor",     2'b10, 3'b100, 7'h00, 8'hF0,  8'h3C,  4'b0011, 8'hCC, 1'b0});
        vecs.push_back('{"sll",     2'b10, 3'b001, 7'h00, 8'h81,  8'h09,  4'b0100, 8'h02, 1'b0});
        vecs.push_back('{"sra",     2'b10, 3'b101, 7'h20, 8'h80,  8'd3,   4'b0111, 8'hF0, 1'b0});
        vecs.push_back('{"srl",     2'b10, 3'b101, 7'h00, 8'h80,  8'd3,   4'b0101, 8'h10, 1'b0});
        vecs.push_back('{"slt",     2'b10, 3'b010, 7'h00, 8'hFF,  8'h01,  4'b1000, 8'h01, 1'b0});
        vecs.push_back('{"sltu",    2'b10, 3'b011, 7'h00, 8'hFF,  8'h01,  4'b1001, 8'h00, 1'b1});
        vecs.push_back('{"r_inv",   2'b10, 3'b000, 7'h01, 8'h12,  8'h34,  4'b1111, 8'h00, 1'b1});
        vecs.push_back('{"i_add",   2'b11, 3'b000, 7'h20, 8'h01,  8'h02,  4'b0010, 8'h03, 1'b0});
        vecs.push_back('{"i_srinv", 2'b11, 3'b101, 7'h01, 8'hAA,  8'h01,  4'b1111, 8'h00, 1'b1});
        vecs.push_back('{"r_srinv", 2'b10, 3'b101, 7'h7F, 8'hAA,  8'h01,  4'b1111, 8'h00, 1'b1});
        vecs.push_back('{"i_slli",  2'b11, 3'b001, 7'h55, 8'h0F,  8'hFC,  4'b0100, 8'hF0, 1'b0});
        vecs.push_back('{"add_wrap",2'b00, 3'b000, 7'h00, 8'h80,  8'h80,  4'b0010, 8'h00, 1'b1});

        foreach (vecs[i]) begin
            aluop = vecs[i].op; funct3 = vecs[i].f3; funct7 = vecs[i].f7;
            a = vecs[i].va; b = vecs[i].vb;
            #1;
            check({vecs[i].name, "_opc"},  aluopc, vecs[i].e_opc);
            check({vecs[i].name, "_res"},  result, vecs[i].e_res);
            check({vecs[i].name, "_zero"}, zero,   vecs[i].e_zero);
        end

        // Randomized stimulus against the reference model
        for (int i = 0; i < 400; i++) begin
            aluop  = 2'($urandom_range(0, 3));
            funct3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0, 1: funct7 = 7'h00;
                2:    funct7 = 7'h20;
                default: funct7 = 7'($urandom);
            endcase
            a = 8'($urandom);
            b = 8'($urandom);
            #1;
            eo = ref_opc(aluop, funct3, funct7);
            er = ref_res(eo, int'(a), int'(b));
            check($sformatf("rnd%0d_opc", i), aluopc, eo);
            check($sformatf("rnd%0d_res", i), result, er);
            check($sformatf("rnd%0d_zero", i), zero, (er == 8'h00));
            #4;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
